// File: rtl/condicionador_sensores.sv
// Sensor front-end: 2-flop sync, shared prescaler, per-channel debounce, valid/change flags.
// Optional stuck-sensor detection is enabled by defining SENSOR_STUCK_DETECT_EN.
module condicionador_sensores #(
    parameter int SAMPLE_DIV     = 1000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int STUCK_TICKS    = 4096
) (
    input  logic clock,
    input  logic reset,
    input  logic head_raw,
    input  logic left_raw,
    input  logic under_raw,
    input  logic barrier_raw,
    output logic head,
    output logic left,
    output logic under,
    output logic barrier,
    output logic sensores_validos,
    output logic mudanca,
    output logic falha_sensor
);

    localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_TICKS) + 1;
    localparam [PW-1:0] PRESC_MAX = PW'(SAMPLE_DIV - 1);
    localparam [CW-1:0] DB_LAST   = CW'(DEBOUNCE_TICKS - 1);
    localparam [CW-1:0] DB_FULL   = CW'(DEBOUNCE_TICKS);
    localparam bit PARAMS_OK = (SAMPLE_DIV >= 1) && (DEBOUNCE_TICKS >= 1) && (STUCK_TICKS >= 1);

    // Guard block: elaborates nothing for legal parameter values.
    if (!PARAMS_OK) begin : g_bad_params
    end

    // Channel order in every vector: {barrier, under, left, head}.
    logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]    deb_q, deb_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] valid_cnt_q, valid_cnt_d;
    logic          valid_q, valid_d;
    logic          mud_q, mud_d;
    logic          tick;

    always_comb begin
        sync1_d     = {barrier_raw, under_raw, left_raw, head_raw};
        sync2_d     = sync1_q;
        tick        = (presc_q == PRESC_MAX);
        presc_d     = tick ? '0 : presc_q + PW'(1);
        deb_d       = deb_q;
        valid_cnt_d = valid_cnt_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (tick) begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
            if (valid_cnt_q != DB_FULL) begin
                valid_cnt_d = valid_cnt_q + CW'(1);
            end
        end
        valid_d = valid_q | (valid_cnt_d == DB_FULL);
        mud_d   = |(deb_d ^ deb_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            presc_q     <= '0;
            valid_cnt_q <= '0;
            valid_q     <= 1'b0;
            mud_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            presc_q     <= presc_d;
            valid_cnt_q <= valid_cnt_d;
            valid_q     <= valid_d;
            mud_q       <= mud_d;
            cnt_q       <= cnt_d;
        end
    end

    assign sensores_validos = valid_q;
    assign mudanca          = mud_q;

`ifdef SENSOR_STUCK_DETECT_EN
    localparam int SW = $clog2(STUCK_TICKS) + 1;
    localparam [SW-1:0] ST_FULL = SW'(STUCK_TICKS);

    logic [SW-1:0] stuck_q [4];
    logic [SW-1:0] stuck_d [4];
    logic          falha_q, falha_d;

    always_comb begin
        falha_d = falha_q;
        for (int i = 0; i < 4; i++) begin
            stuck_d[i] = stuck_q[i];
            if (stuck_q[i] == ST_FULL) begin
                falha_d = 1'b1;
            end
            if (tick) begin
                if (!deb_q[i]) begin
                    stuck_d[i] = '0;
                end else if (stuck_q[i] != ST_FULL) begin
                    stuck_d[i] = stuck_q[i] + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            falha_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                stuck_q[i] <= '0;
            end
        end else begin
            falha_q <= falha_d;
            stuck_q <= stuck_d;
        end
    end

    // A stuck sensor forces head+barrier high so navigation drops to StandBy.
    assign head         = deb_q[0] | falha_q;
    assign left         = deb_q[1];
    assign under        = deb_q[2];
    assign barrier      = deb_q[3] | falha_q;
    assign falha_sensor = falha_q;
`else
    assign head         = deb_q[0];
    assign left         = deb_q[1];
    assign under        = deb_q[2];
    assign barrier      = deb_q[3];
    assign falha_sensor = 1'b0;
`endif

endmodule

// File: tb/tb_condicionador_sensores.sv
// Bench for condicionador_sensores: tick-history model checked every cycle plus directed literal checks.
module tb_condicionador_sensores;

    localparam int SD = 4;
    localparam int D  = 3;
    localparam int ST = 16;
`ifdef SENSOR_STUCK_DETECT_EN
    localparam bit STUCK_EN = 1'b1;
`else
    localparam bit STUCK_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic head_raw = 1'b0, left_raw = 1'b0, under_raw = 1'b0, barrier_raw = 1'b0;
    logic head, left, under, barrier, sensores_validos, mudanca, falha_sensor;

    int checks   = 0;
    int failures = 0;
    int mud_cnt  = 0;

    condicionador_sensores #(
        .SAMPLE_DIV    (SD),
        .DEBOUNCE_TICKS(D),
        .STUCK_TICKS   (ST)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .head_raw        (head_raw),
        .left_raw        (left_raw),
        .under_raw       (under_raw),
        .barrier_raw     (barrier_raw),
        .head            (head),
        .left            (left),
        .under           (under),
        .barrier         (barrier),
        .sensores_validos(sensores_validos),
        .mudanca         (mudanca),
        .falha_sensor    (falha_sensor)
    );

    always #5 clock = ~clock;

    // Model: keeps every tick-time sample since reset; a channel flips when the
    // last D samples since its previous acceptance all disagree with its level.
    int         cyc = 0;
    logic [3:0] r1 = '0, r2 = '0, m_deb = '0, m_s, m_prev;
    logic       m_mud = 1'b0, m_falha = 1'b0;
    logic [3:0] samp_q[$];
    int         acc_idx[4] = '{0, 0, 0, 0};
    int         m_n;
    bit         m_flip;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc = 0; r1 = '0; r2 = '0; m_deb = '0; m_mud = 1'b0; m_falha = 1'b0;
            samp_q.delete();
            for (int i = 0; i < 4; i++) acc_idx[i] = 0;
        end else begin
            m_s = r2;
            m_prev = m_deb;
            if (STUCK_EN) begin
                for (int i = 0; i < 4; i++)
                    if (m_deb[i] && (samp_q.size() - acc_idx[i] >= ST)) m_falha = 1'b1;
            end
            if (cyc % SD == SD - 1) begin
                samp_q.push_back(m_s);
                m_n = samp_q.size();
                for (int ch = 0; ch < 4; ch++) begin
                    if (m_n - acc_idx[ch] >= D) begin
                        m_flip = 1'b1;
                        for (int k = m_n - D; k < m_n; k++)
                            if (samp_q[k][ch] == m_deb[ch]) m_flip = 1'b0;
                        if (m_flip) begin
                            m_deb[ch] = m_s[ch];
                            acc_idx[ch] = m_n;
                        end
                    end
                end
            end
            m_mud = (m_deb != m_prev);
            r2 = r1;
            r1 = {barrier_raw, under_raw, left_raw, head_raw};
            cyc++;
        end
    end

    logic [6:0] exp_v, act_v;
    logic       f_eff;

    always @(negedge clock) begin
        f_eff = STUCK_EN && m_falha;
        exp_v = {m_deb[0] | f_eff, m_deb[1], m_deb[2], m_deb[3] | f_eff,
                 samp_q.size() >= D, m_mud, f_eff};
        act_v = {head, left, under, barrier, sensores_validos, mudanca, falha_sensor};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL cycle_cmp t=%0t got=%b want=%b (h,l,u,b,valid,mud,falha)", $time, act_v, exp_v);
        end
        if (mudanca === 1'b1) mud_cnt++;
    end

    task automatic chk(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        // 1: reset and validity timing
        cycles(3);
        chk("rst_head", head, 1'b0);
        chk("rst_valid", sensores_validos, 1'b0);
        chk("rst_falha", falha_sensor, 1'b0);
        #2 reset = 1'b0;
        cycles(11);
        chk("valid_before_3rd_tick", sensores_validos, 1'b0);
        cycles(1);
        chk("valid_after_3rd_tick", sensores_validos, 1'b1);

        // 2: head rise latency and single mudanca pulse
        head_raw = 1'b1;
        cycles(11);
        chk("head_not_yet", head, 1'b0);
        cycles(1);
        chk("head_rise", head, 1'b1);
        chk("head_mud_pulse", mudanca, 1'b1);
        cycles(1);
        chk("head_mud_end", mudanca, 1'b0);

        // 3: two-tick barrier glitch rejected, three-tick level accepted
        mud_cnt = 0;
        barrier_raw = 1'b1;
        cycles(8);
        barrier_raw = 1'b0;
        cycles(12);
        chk("glitch_barrier", barrier, 1'b0);
        chk_int("glitch_no_mud", mud_cnt, 0);
        barrier_raw = 1'b1;
        cycles(20);
        chk("barrier_held", barrier, 1'b1);

        // 4: simultaneous left/under change gives one pulse
        mud_cnt = 0;
        left_raw = 1'b1;
        under_raw = 1'b1;
        cycles(20);
        chk("left_up", left, 1'b1);
        chk("under_up", under, 1'b1);
        chk_int("pair_one_pulse", mud_cnt, 1);

        head_raw = 1'b0; left_raw = 1'b0; under_raw = 1'b0; barrier_raw = 1'b0;
        cycles(20);
        chk("all_down_head", head, 1'b0);
        chk("all_down_barrier", barrier, 1'b0);

        // 5: reset mid-count discards partial debounce
        under_raw = 1'b1;
        cycles(10);
        #2 reset = 1'b1;
        #1;
        chk("midrst_under", under, 1'b0);
        chk("midrst_valid", sensores_validos, 1'b0);
        cycles(2);
        #2 reset = 1'b0;
        cycles(11);
        chk("postrst_under_wait", under, 1'b0);
        cycles(1);
        chk("postrst_under_up", under, 1'b1);
        chk("postrst_valid", sensores_validos, 1'b1);
        under_raw = 1'b0;
        cycles(20);

        // 6: long left level; stuck flag only with the optional feature
        left_raw = 1'b1;
        cycles(100);
        left_raw = 1'b0;
        cycles(30);
        chk("stuck_falha", falha_sensor, STUCK_EN);
        chk("stuck_head", head, STUCK_EN);
        chk("stuck_barrier", barrier, STUCK_EN);
        chk("stuck_left_clean", left, 1'b0);

        #2 reset = 1'b1;
        cycles(1);
        chk("final_rst_falha", falha_sensor, 1'b0);
        chk("final_rst_head", head, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/condicionador_sensores.md
Name: condicionador_sensores

Overview:
Sensor front-end directly upstream of the robot navigation FSM. Takes the four raw, asynchronous, bouncy sensor lines (head, left, under, barrier). Synchronises, prescales and debounces each line, then presents clean, registered levels to the FSM. Also flags when sensor data is valid and pulses when any cleaned level changes.

Parameters:
SAMPLE_DIV, 1000, clock cycles per debounce sample tick (>=1; 1 = tick every cycle)
DEBOUNCE_TICKS, 4, consecutive ticks a new level must persist before it is accepted (>=1)
STUCK_TICKS, 4096, ticks a cleaned level may stay 1 before it is declared stuck (used only with the optional feature)

Ports:
clock  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
head_raw  in  1  raw front obstacle sensor
left_raw  in  1  raw left obstacle sensor
under_raw  in  1  raw floor/under sensor
barrier_raw  in  1  raw debris/barrier sensor
head  out  1  debounced head level, to navigation FSM
left  out  1  debounced left level
under  out  1  debounced under level
barrier  out  1  debounced barrier level
sensores_validos  out  1  sticky 1 once the first full debounce window has elapsed after reset
mudanca  out  1  one-cycle pulse: some debounced level changed
falha_sensor  out  1  sticky stuck-sensor flag (tied 0 when the feature is disabled)

Behaviour:
- Reset (async assert): all synchroniser flops, debounced levels, counters and outputs go to 0. The prescaler restarts at 0. Reset mid-operation discards every partial count.
- Synchroniser: 2 flops per raw line, reset 0. Debounce logic sees only the second-stage value s.
- Prescaler: counts 0..SAMPLE_DIV-1. tick=1 for one cycle when the count equals SAMPLE_DIV-1, then the count wraps to 0. With SAMPLE_DIV=1, tick is permanently 1.
- Per-channel debounce. Each channel has cnt of width clog2(DEBOUNCE_TICKS)+1. On each tick:
  - if s == deb: cnt <= 0
  - else if cnt == DEBOUNCE_TICKS-1: deb <= s, cnt <= 0
  - else: cnt <= cnt+1
  - No action on non-tick cycles.
  - Any tick where s agrees with deb restarts the window.
- Channels are fully independent. Several channels may update on the same tick.
- Latency, raw edge to output edge: 2 cycles of synchroniser, plus DEBOUNCE_TICKS ticks, plus up to SAMPLE_DIV-1 cycles of tick phase.
- Outputs are registered on posedge. The FSM samples on negedge, giving a half-cycle setup margin. No combinational path from raw inputs to outputs.
- sensores_validos:
  - a separate tick counter counts to DEBOUNCE_TICKS after reset
  - on reaching it, sensores_validos <= 1, sticky until reset
  - the counter then saturates
- mudanca: registered. It is 1 in the cycle after any deb bit changed, otherwise 0. Simultaneous changes on several channels give a single pulse. It fires regardless of sensores_validos.
- Glitches shorter than DEBOUNCE_TICKS ticks never reach the outputs.

Optional Feature:
SENSOR_STUCK_DETECT_EN
- Defined:
  - Each channel has a stuck counter. On each tick it increments, saturating, while deb==1, and clears when deb==0.
  - When any counter reaches STUCK_TICKS, falha_sensor <= 1, sticky until reset.
  - While falha_sensor=1, outputs head and barrier are forced to 1. This pattern drives the navigation FSM to StandBy.
  - left and under pass through unchanged.
  - mudanca still reflects only genuine deb changes.
- Undefined:
  - No stuck counters are instantiated.
  - falha_sensor is constant 0.
  - Outputs are always the raw deb values.

Test Plan:
Test parameters: SAMPLE_DIV=4, DEBOUNCE_TICKS=3, STUCK_TICKS=16.
1. Release reset, all raw lines held 0 → all outputs 0. sensores_validos rises 1 cycle after the 3rd tick (~cycle 12) and stays 1.
2. head_raw 0→1 held steady → head rises after the 3rd tick seen post-sync (≤2+12 cycles). mudanca is high for exactly 1 cycle after head rises.
3. barrier_raw high for 2 ticks, then low → barrier stays 0 and mudanca never pulses. Then hold it high for 3 ticks → barrier=1.
4. left_raw and under_raw toggle together and are held → both outputs change on the same cycle with one single mudanca pulse.
5. Assert reset while the under count is at 2 → all outputs 0 immediately. After release, 3 fresh ticks are required before under=1.
6. With SENSOR_STUCK_DETECT_EN: hold left_raw=1 for 16+ ticks after acceptance → falha_sensor=1 and head=barrier=1 while the raw lines are 0, holding until reset. Without the macro the same stimulus leaves falha_sensor=0 and head=barrier=0.
